// File: rtl/fetch_buffer.sv
// fetch_buffer: decouples the instruction fetch unit from decode.
// Each accepted fetch result has its 32-bit instruction word extracted from
// the I-cache line and is held in a small circular FIFO. A fetch fault is
// stored as a single faulting entry. After that, all input is dropped until a
// flush or reset redirects the front end.
// Optional feature: define RAFI_FETCH_BUFFER_BYPASS_EN so that an empty queue
// forwards the incoming fetch result combinationally to decode. In the default
// build this feature is off and the design is a pure one-cycle-latency queue.
module fetch_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inValid,
    input  logic                    inFault,
    input  logic [31:0]             inPc,
    input  logic [LINE_BYTES*8-1:0] inLine,
    output logic                    stall,
    input  logic                    flush,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [31:0]             outInsn,
    output logic [31:0]             outPc,
    output logic                    outFault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = LINE_BYTES / 4;

    // Select the little-endian word of the line addressed by pc; pc[1:0] is ignored.
    function automatic logic [31:0] extract_word(input logic [LINE_BYTES*8-1:0] line,
                                                 input logic [31:0]             pc);
        logic [31:0] idx;
        logic [31:0] word;
        idx  = (pc >> 2) & 32'(WORDS - 1);
        word = 32'h0000_0000;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == 32'(i)) begin
                word = line[i*32 +: 32];
            end else begin
                word = word;
            end
        end
        return word;
    endfunction

    // Queue storage; data is only observed through the count-gated head.
    logic [31:0]      insn_mem_q  [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];
    logic             fault_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             fault_pending_q, fault_pending_d;

    logic             head_valid_s;
    logic             stall_s;
    logic             bypass_s;
    logic             accept_s;
    logic             enq_s;
    logic             deq_s;
    logic [31:0]      in_insn_s;

    assign head_valid_s = (count_q != {CNT_W{1'b0}});
    assign stall_s      = (count_q == CNT_W'(DEPTH));
    assign in_insn_s    = inFault ? 32'h0000_0000 : extract_word(inLine, inPc);

`ifdef RAFI_FETCH_BUFFER_BYPASS_EN
    assign bypass_s = !head_valid_s && inValid && !flush && !fault_pending_q;
`else
    assign bypass_s = 1'b0;
`endif

    // An input is accepted when there is room, no flush and no outstanding fault.
    assign accept_s = inValid && !stall_s && !flush && !fault_pending_q;
    // A bypassed input consumed by decode in the same cycle is never written.
    assign enq_s    = accept_s && !(bypass_s && outReady);
    assign deq_s    = head_valid_s && outReady && !flush;

    // Next-state for pointers, occupancy and the sticky fault flag.
    always_comb begin
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        fault_pending_d = fault_pending_q;
        if (flush) begin
            rd_ptr_d        = {PTR_W{1'b0}};
            wr_ptr_d        = {PTR_W{1'b0}};
            count_d         = {CNT_W{1'b0}};
            fault_pending_d = 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (accept_s && inFault) begin
                fault_pending_d = 1'b1;
            end else begin
                fault_pending_d = fault_pending_q;
            end
        end
    end

    // Control state register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= {PTR_W{1'b0}};
            wr_ptr_q        <= {PTR_W{1'b0}};
            count_q         <= {CNT_W{1'b0}};
            fault_pending_q <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            fault_pending_q <= fault_pending_d;
        end
    end

    // Write the accepted entry at the tail; reset suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enq_s) begin
            insn_mem_q[wr_ptr_q]  <= in_insn_s;
            pc_mem_q[wr_ptr_q]    <= inPc;
            fault_mem_q[wr_ptr_q] <= inFault;
        end
    end

    // Present the head entry, the bypassed input, or zeros when nothing is valid.
    always_comb begin
        outValid = 1'b0;
        outInsn  = 32'h0000_0000;
        outPc    = 32'h0000_0000;
        outFault = 1'b0;
        if (head_valid_s) begin
            outValid = 1'b1;
            outInsn  = insn_mem_q[rd_ptr_q];
            outPc    = pc_mem_q[rd_ptr_q];
            outFault = fault_mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            outValid = 1'b1;
            outInsn  = in_insn_s;
            outPc    = inPc;
            outFault = inFault;
        end else begin
            outValid = 1'b0;
        end
    end

    assign stall = stall_s;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam int LB    = 16;
    localparam int LW    = LB * 8;
`ifdef RAFI_FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, inValid, inFault, flush, outReady;
    logic [31:0]   inPc;
    logic [LW-1:0] inLine;
    logic          stall, outValid, outFault;
    logic [31:0]   outInsn, outPc;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t mq[$];
    bit   mfp;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .LINE_BYTES(LB)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inFault(inFault),
        .inPc(inPc), .inLine(inLine), .stall(stall), .flush(flush),
        .outValid(outValid), .outReady(outReady), .outInsn(outInsn),
        .outPc(outPc), .outFault(outFault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Word at byte offset (pc mod line size) rounded down to 4, little-endian.
    function automatic logic [31:0] model_word(input logic [LW-1:0] line, input logic [31:0] pc);
        int base;
        logic [7:0] b [4];
        base = int'((pc % 32'(LB)) & ~32'd3);
        for (int k = 0; k < 4; k++) b[k] = line[(base + k)*8 +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW/32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Apply one cycle of inputs, compare outputs with the model, advance both.
    task automatic step(input logic v, input logic f, input logic [31:0] pc,
                        input logic [LW-1:0] line, input logic fl,
                        input logic rdy, input logic r);
        bit byp, deq, acc, enq;
        logic ev, ef;
        logic [31:0] ei, ep;
        ent_t e;
        inValid = v; inFault = f; inPc = pc; inLine = line;
        flush = fl; outReady = rdy; rst = r;
        #1;
        byp = BYP && mq.size() == 0 && v && !fl && !mfp;
        ev = 1'b0; ei = 32'h0; ep = 32'h0; ef = 1'b0;
        if (mq.size() != 0) begin
            ev = 1'b1; ei = mq[0].insn; ep = mq[0].pc; ef = mq[0].fault;
        end else if (byp) begin
            ev = 1'b1; ei = f ? 32'h0 : model_word(line, pc); ep = pc; ef = f;
        end
        check("outValid", 32'(outValid), 32'(ev));
        check("outInsn", outInsn, ei);
        check("outPc", outPc, ep);
        check("outFault", 32'(outFault), 32'(ef));
        check("stall", 32'(stall), 32'(mq.size() == DEPTH));
        if (r || fl) begin
            mq.delete();
            mfp = 1'b0;
        end else begin
            deq = mq.size() != 0 && rdy;
            acc = v && mq.size() != DEPTH && !mfp;
            enq = acc && !(byp && rdy);
            if (deq) void'(mq.pop_front());
            if (enq) begin
                e.insn = f ? 32'h0 : model_word(line, pc);
                e.pc = pc; e.fault = f;
                mq.push_back(e);
            end
            if (acc && f) mfp = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 32'h0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input logic rdy);
        step(1'b1, 1'b0, pc, rand_line(), 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [LW-1:0] l34;
        rst = 1'b1; inValid = 1'b0; inFault = 1'b0; inPc = 32'h0;
        inLine = '0; flush = 1'b0; outReady = 1'b0;
        mfp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // Post-reset outputs are zero; the model comparison inside step covers them.
        idle(1'b0);

        // Word extraction with one-cycle latency.
        l34 = 128'h44332211_88776655_CCBBAA99_00FFEEDD;
        step(1'b1, 1'b0, 32'h1004, l34, 1'b0, 1'b0, 1'b0);
        check("x34_valid", 32'(outValid), 32'd1);
        check("x34_insn", outInsn, 32'hCCBBAA99);
        check("x34_pc", outPc, 32'h1004);
        check("x34_fault", 32'(outFault), 32'd0);

        // Fill to full with decode blocked, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'(i * 4), 1'b0);
            if (i == 3) check("x35_stall", 32'(stall), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            check("x35_order", outPc, 32'(i * 4));
            idle(1'b1);
        end
        check("x35_empty", 32'(outValid), 32'd0);

        // Full queue with a sustained stream: first cycle cannot enqueue.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 1'b0);
        push(32'h200, 1'b1);
        check("x36_first", 32'(stall), 32'd0);
        for (int i = 1; i < 20; i++) push(32'h200 + 32'(i * 4), 1'b1);

        // Fault blocks further input until flush.
        do_reset();
        step(1'b1, 1'b1, 32'h2000, rand_line(), 1'b0, 1'b0, 1'b0);
        push(32'h2004, 1'b0);
        push(32'h2008, 1'b0);
        check("x37_fault", 32'(outFault), 32'd1);
        check("x37_insn", outInsn, 32'h0);
        check("x37_pc", outPc, 32'h2000);
        idle(1'b1);
        check("x37_none", 32'(outValid), 32'd0);
        push(32'h200C, 1'b0);
        check("x37_drop", 32'(outValid), 32'd0);
        step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        push(32'h3000, 1'b0);
        check("x37_post", outPc, 32'h3000);

        // Flush wins over enqueue and dequeue.
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(i * 4), 1'b0);
        step(1'b1, 1'b0, 32'h600, rand_line(), 1'b1, 1'b1, 1'b0);
        check("x38_flush", 32'(outValid), 32'd0);
        idle(1'b0);

`ifdef RAFI_FETCH_BUFFER_BYPASS_EN
        do_reset();
        step(1'b1, 1'b0, 32'h4000, rand_line(), 1'b0, 1'b1, 1'b0);
        check("x39_valid", 32'(outValid), 32'd1);
        check("x39_pc", outPc, 32'h4000);
        idle(1'b0);
        check("x39_count", 32'(outValid), 32'd0);
`endif

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 10) < 7,
                 ($urandom % 100) < 3,
                 32'h8000 + ($urandom % 64) * 4 + ($urandom % 4),
                 rand_line(),
                 ($urandom % 100) < 4,
                 ($urandom % 10) < 6,
                 ($urandom % 100) < 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 4, queue entries; power of two, 2..16.
REQ-002 SHALL have parameter LINE_BYTES, 16, I-cache line size in bytes; power of two, 4..64.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port inValid  in  1  fetch-unit result valid.
REQ-006 SHALL have port inFault  in  1  fetch-unit access fault for inPc.
REQ-007 SHALL have port inPc  in  32  fetch address, 4-byte aligned.
REQ-008 SHALL have port inLine  in  LINE_BYTES*8  I-cache line containing inPc.
REQ-009 SHALL have port stall  out  1  back-pressure to fetch unit; high means the input is not accepted this cycle.
REQ-010 SHALL have port flush  in  1  discard all entries (branch redirect, fence.i, sfence.vma).
REQ-011 SHALL have port outValid  out  1  decode-side entry valid.
REQ-012 SHALL have port outReady  in  1  decode accepts the entry.
REQ-013 SHALL have port outInsn  out  32  instruction word.
REQ-014 SHALL have port outPc  out  32  instruction address.
REQ-015 SHALL have port outFault  out  1  instruction fetch faulted.

Function
REQ-016 SHALL extract outInsn from inLine at byte offset inPc[log2(LINE_BYTES)-1:2]*4, little-endian; inPc[1:0] ignored.
REQ-017 SHALL store {insn, pc, fault} per entry in a DEPTH-entry circular FIFO; read/write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-018 SHALL enqueue when inValid && !stall && !flush && !faultPending.
REQ-019 SHALL dequeue when outValid && outReady && !flush.
REQ-020 SHALL drive stall = (count == DEPTH); a simultaneous dequeue does not lift stall in the same cycle.
REQ-021 SHALL, with enqueue and dequeue in the same cycle, leave count unchanged and advance both pointers.
REQ-022 SHALL drive outValid = (count != 0) and present the head entry; outInsn, outPc and outFault SHALL hold stable while outValid && !outReady.
REQ-023 SHALL store a faulting entry with insn = 0 and fault = 1, and set faultPending.
REQ-024 SHALL, while faultPending, drop all inputs without enqueue (stall stays per REQ-020); faultPending clears only on flush or rst.
REQ-025 SHALL on flush: zero count and pointers, clear faultPending, deassert outValid next cycle; flush SHALL take priority over enqueue and dequeue in the same cycle.
REQ-026 SHALL give one-cycle latency: an entry accepted at edge N is visible on the outputs after edge N.

Reset
REQ-027 SHALL on rst: count = 0, read/write pointers = 0, faultPending = 0; rst SHALL take priority over flush and all handshakes.
REQ-028 SHALL output after reset: outValid = 0, stall = 0, outInsn = 0, outPc = 0, outFault = 0.
REQ-029 SHALL drive outInsn, outPc and outFault to 0 whenever outValid = 0.
REQ-030 SHALL, on reset asserted mid-stream, lose all entries with no dequeue that cycle.

Configuration
REQ-031 SHALL honour macro RAFI_FETCH_BUFFER_BYPASS_EN.
REQ-032 SHALL, with the macro defined, when count == 0 && inValid && !flush && !faultPending: drive outputs combinationally from the inputs with outValid = 1; if outReady is also high, not write the entry; otherwise enqueue it per REQ-018.
REQ-033 SHALL, with the macro undefined, have no combinational path from in* to out*; latency is exactly REQ-026.

Verification
REQ-034 SHALL cover: line 0x44332211_88776655_CCBBAA99_00FFEEDD, inPc 0x1004 -> outInsn 0xCCBBAA99, outPc 0x1004, outFault 0, one cycle later (bypass off).
REQ-035 SHALL cover: outReady = 0, 5 inputs at PCs 0x0,0x4,0x8,0xC,0x10 -> stall = 1 after the 4th; the 5th is not accepted; raise outReady -> drain 0x0,0x4,0x8,0xC in order.
REQ-036 SHALL cover: full queue, outReady = 1, inValid = 1 -> no enqueue in the first cycle; sustained stream thereafter has count stable at DEPTH-1 or DEPTH with no loss.
REQ-037 SHALL cover: inFault = 1 at 0x2000, then valid inputs at 0x2004 and 0x2008 -> one entry out with outFault = 1, outInsn = 0; nothing else until flush; a post-flush input at 0x3000 is delivered.
REQ-038 SHALL cover: 3 entries queued, then flush with inValid = 1 and outReady = 1 -> outValid = 0 next cycle, no dequeue, input dropped.
REQ-039 SHALL cover: bypass on, empty, inValid = 1 at 0x4000 with outReady = 1 -> outValid = 1 in the same cycle, count stays 0.
